hist_seq_ctrl: RTL
==================

Name: hist_seq_ctrl

Overview:
Command sequencer for the histogram-equalization datapath. It converts the three operator controls (original histogram, equalize, equalized histogram) into ordered start/done phases for the shared engines: histogram RAM clear, histogram accumulate, CDF build and pixel remap. It tracks which results are valid, auto-chains missing prerequisites, rejects conflicting commands and drives the display select and status LEDs.

Parameters:
TIMEOUT, 200000, max cycles a phase may wait for its done before error (covers 65536-pixel passes)
CNT_W, 18, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
hist_clk  in  1  system clock
reset  in  1  asynchronous active-high reset
origin_hist_ctrl  in  1  command level: build histogram of original image
equalize_ctrl  in  1  command level: equalize image
eqlzed_hist_ctrl  in  1  command level: build histogram of equalized image
clr_start  out  1  one-cycle pulse: clear histogram RAM
clr_done  in  1  clear engine finished
acc_start  out  1  one-cycle pulse: accumulate histogram pass
acc_src  out  1  accumulate source: 0 original image, 1 equalized image
acc_done  in  1  accumulate finished
cdf_start  out  1  one-cycle pulse: build CDF/LUT from histogram RAM
cdf_done  in  1  CDF finished
map_start  out  1  one-cycle pulse: remap pixels through LUT
map_done  in  1  remap finished
hist_switch  out  1  display select: 0 original histogram, 1 equalized histogram
busy  out  1  a sequence is running
cmd_reject  out  1  one-cycle pulse: a command edge was discarded
error  out  1  watchdog expired (sticky)
condition_led  out  4  [0] orig_valid, [1] map_valid, [2] eq_valid, [3] busy|error

Behaviour:
- Reset (async): state IDLE; all outputs 0; orig_valid, map_valid, eq_valid, error, watchdog and synchronizers cleared. Asserting reset mid-sequence aborts immediately. Engines see no further start.
- Inputs: each passes through a 2-FF synchronizer and a rising-edge detector. If a level is first sampled high at edge N, the edge is acted on at edge N+2. The resulting start pulse is high from N+2 to N+3. Held levels give one edge only.
- Simultaneous edges: priority origin > equalize > eqlzed. The winner is accepted; each loser produces a cmd_reject pulse (one pulse total per cycle).
- Any edge arriving while busy=1, or in ERR other than origin, is rejected with a cmd_reject pulse.
- States: IDLE, CLR, ACC, CDF, MAP, ERR. Entering CLR, ACC, CDF or MAP registers the matching *_start high for exactly one cycle. The watchdog is cleared on entry.
- A phase exits on the first done sampled high at or after the cycle following its start. Done coincident with the start cycle is ignored. Done inputs are ignored in other states.
- Sequences (busy=1 from acceptance until return to IDLE):
  - origin: CLR -> ACC(acc_src=0) -> IDLE. On acceptance: eq_valid=0, map_valid=0, orig_valid=0. On ACC done: orig_valid=1, hist_switch=0.
  - equalize: if orig_valid=1: CDF -> MAP -> IDLE. Otherwise auto-chain CLR -> ACC(0) (sets orig_valid) -> CDF -> MAP. On MAP done: map_valid=1, eq_valid=0.
  - eqlzed: requires map_valid=1, else rejected. Runs CLR -> ACC(acc_src=1) -> IDLE. On acceptance: orig_valid=0, because the shared RAM is being overwritten. On ACC done: eq_valid=1, hist_switch=1.
- acc_src holds its value for the whole ACC phase and retains it in IDLE.
- Watchdog: counts cycles in CLR, ACC, CDF or MAP. When the count reaches TIMEOUT without done, go to ERR and set error=1. All valid flags are cleared and busy=0.
- ERR exits only on an origin edge, which clears error and starts the origin sequence, or on reset.
- Flag updates and state transitions take effect on the same edge.

Test Plan:
- Reset for 10 cycles, release, then pulse origin for 10 cycles with clr_done and acc_done returned 5 cycles after each start -> clr_start and acc_start each pulse exactly once, in that order, acc_src=0. End state: condition_led=4'b0001, busy=0, hist_switch=0.
- From reset, pulse equalize only -> auto-chain issues clr, acc, cdf and map starts in order. End: condition_led=4'b0011.
- After equalize completes, pulse eqlzed -> clr then acc with acc_src=1. End: hist_switch=1, condition_led=4'b0110. Pulsing equalize next re-chains CLR -> ACC(0) -> CDF -> MAP.
- eqlzed from reset -> single cmd_reject pulse, no start pulses, busy stays 0. Origin and equalize rising in the same cycle -> origin runs, one cmd_reject. Any command during ACC -> cmd_reject, sequence unaffected.
- TIMEOUT=100, withhold acc_done -> exactly 100 cycles after acc_start, error=1 and condition_led=4'b1000. An origin pulse then restarts and completes normally.
- Assert reset midway through MAP -> all outputs 0 asynchronously, and a later map_done has no effect.

Source files
------------

// File: rtl/hist_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : hist_seq_if
// Purpose  : Command, engine-handshake and status bundle for hist_seq_ctrl.
//            master : the sequencer (drives starts/status, reads cmds/dones)
//            slave  : the operator/engine side
// Signals  : origin_hist_ctrl, equalize_ctrl, eqlzed_hist_ctrl  command levels
//            clr/acc/cdf/map _start  one-cycle engine start pulses
//            clr/acc/cdf/map _done   engine completion inputs
//            acc_src, hist_switch, busy, cmd_reject, error, condition_led[3:0]
// Revision : 1.0  initial release
// ============================================================================
interface hist_seq_if;
  logic       origin_hist_ctrl;
  logic       equalize_ctrl;
  logic       eqlzed_hist_ctrl;
  logic       clr_start;
  logic       clr_done;
  logic       acc_start;
  logic       acc_src;
  logic       acc_done;
  logic       cdf_start;
  logic       cdf_done;
  logic       map_start;
  logic       map_done;
  logic       hist_switch;
  logic       busy;
  logic       cmd_reject;
  logic       error;
  logic [3:0] condition_led;

  modport master (
    input  origin_hist_ctrl, equalize_ctrl, eqlzed_hist_ctrl,
    input  clr_done, acc_done, cdf_done, map_done,
    output clr_start, acc_start, acc_src, cdf_start, map_start,
    output hist_switch, busy, cmd_reject, error, condition_led
  );

  modport slave (
    output origin_hist_ctrl, equalize_ctrl, eqlzed_hist_ctrl,
    output clr_done, acc_done, cdf_done, map_done,
    input  clr_start, acc_start, acc_src, cdf_start, map_start,
    input  hist_switch, busy, cmd_reject, error, condition_led
  );
endinterface
`default_nettype wire

// File: rtl/hist_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hist_seq_ctrl
// Purpose  : Sequencer for the histogram-equalization datapath. Turns operator
//            command levels into ordered clear/accumulate/CDF/remap phases,
//            tracks result validity, auto-chains prerequisites, rejects
//            conflicting commands and guards every phase with a watchdog.
// Ports    : hist_clk  system clock
//            reset     asynchronous active-high reset
//            bus       hist_seq_if.master (commands, engine handshakes, status)
// Revision : 1.0  initial release
// ============================================================================
module hist_seq_ctrl #(
  parameter int TIMEOUT = 200000,
  parameter int CNT_W   = 18
) (
  input  logic       hist_clk,
  input  logic       reset,
  hist_seq_if.master bus
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WD_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_ACC  = 3'd2,
    S_CDF  = 3'd3,
    S_MAP  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] wdog_q;
  logic             clr_start_q, acc_start_q, cdf_start_q, map_start_q;
  logic             acc_src_q, hist_switch_q, busy_q, cmd_reject_q, error_q;
  logic             orig_valid_q, map_valid_q, eq_valid_q;
  logic             chain_q;   // equalize was accepted without a valid histogram

  // Command synchronizers and rising-edge detect; bit order {eqlzed, equalize, origin}
  logic [2:0] cmd_raw, sync1_q, sync2_q, prev_q, rise;

  assign cmd_raw = {bus.eqlzed_hist_ctrl, bus.equalize_ctrl, bus.origin_hist_ctrl};

  always_ff @(posedge hist_clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= cmd_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

  // Command arbitration: at most one winner, and one reject pulse covers all losers
  logic go_orig, go_eq, go_eql, rej;

  always_comb begin
    go_orig = 1'b0;
    go_eq   = 1'b0;
    go_eql  = 1'b0;
    rej     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise[0]) begin
          go_orig = 1'b1;
          rej     = rise[1] | rise[2];
        end else if (rise[1]) begin
          go_eq = 1'b1;
          rej   = rise[2];
        end else if (rise[2]) begin
          go_eql = map_valid_q;
          rej    = ~map_valid_q;
        end
      end
      S_ERR: begin
        go_orig = rise[0];
        rej     = rise[0] ? (rise[1] | rise[2]) : (|rise);
      end
      default: rej = |rise;
    endcase
  end

  // A done asserted during the start cycle belongs to a previous run and is ignored
  logic phase_done, in_phase;

  always_comb begin
    phase_done = 1'b0;
    case (state_q)
      S_CLR:   phase_done = bus.clr_done & ~clr_start_q;
      S_ACC:   phase_done = bus.acc_done & ~acc_start_q;
      S_CDF:   phase_done = bus.cdf_done & ~cdf_start_q;
      S_MAP:   phase_done = bus.map_done & ~map_start_q;
      default: phase_done = 1'b0;
    endcase
  end

  assign in_phase = (state_q == S_CLR) || (state_q == S_ACC) ||
                    (state_q == S_CDF) || (state_q == S_MAP);

  always_ff @(posedge hist_clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wdog_q        <= '0;
      clr_start_q   <= 1'b0;
      acc_start_q   <= 1'b0;
      cdf_start_q   <= 1'b0;
      map_start_q   <= 1'b0;
      acc_src_q     <= 1'b0;
      hist_switch_q <= 1'b0;
      busy_q        <= 1'b0;
      cmd_reject_q  <= 1'b0;
      error_q       <= 1'b0;
      orig_valid_q  <= 1'b0;
      map_valid_q   <= 1'b0;
      eq_valid_q    <= 1'b0;
      chain_q       <= 1'b0;
    end else begin
      clr_start_q  <= 1'b0;
      acc_start_q  <= 1'b0;
      cdf_start_q  <= 1'b0;
      map_start_q  <= 1'b0;
      cmd_reject_q <= rej;

      if (go_orig) begin
        state_q      <= S_CLR;
        clr_start_q  <= 1'b1;
        wdog_q       <= '0;
        busy_q       <= 1'b1;
        error_q      <= 1'b0;
        acc_src_q    <= 1'b0;
        chain_q      <= 1'b0;
        orig_valid_q <= 1'b0;
        map_valid_q  <= 1'b0;
        eq_valid_q   <= 1'b0;
      end else if (go_eq) begin
        wdog_q  <= '0;
        busy_q  <= 1'b1;
        chain_q <= ~orig_valid_q;
        if (orig_valid_q) begin
          state_q     <= S_CDF;
          cdf_start_q <= 1'b1;
        end else begin
          state_q     <= S_CLR;
          clr_start_q <= 1'b1;
          acc_src_q   <= 1'b0;
        end
      end else if (go_eql) begin
        state_q      <= S_CLR;
        clr_start_q  <= 1'b1;
        wdog_q       <= '0;
        busy_q       <= 1'b1;
        acc_src_q    <= 1'b1;
        chain_q      <= 1'b0;
        orig_valid_q <= 1'b0;   // shared RAM is about to be overwritten
      end else if (in_phase) begin
        if (phase_done) begin
          wdog_q <= '0;
          case (state_q)
            S_CLR: begin
              state_q     <= S_ACC;
              acc_start_q <= 1'b1;
            end
            S_ACC: begin
              if (acc_src_q) begin
                eq_valid_q    <= 1'b1;
                hist_switch_q <= 1'b1;
                state_q       <= S_IDLE;
                busy_q        <= 1'b0;
              end else begin
                orig_valid_q  <= 1'b1;
                hist_switch_q <= 1'b0;
                if (chain_q) begin
                  state_q     <= S_CDF;
                  cdf_start_q <= 1'b1;
                end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
            S_CDF: begin
              state_q     <= S_MAP;
              map_start_q <= 1'b1;
            end
            default: begin
              map_valid_q <= 1'b1;
              eq_valid_q  <= 1'b0;
              chain_q     <= 1'b0;
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
            end
          endcase
        end else if (wdog_q == WD_LAST) begin
          state_q      <= S_ERR;
          error_q      <= 1'b1;
          busy_q       <= 1'b0;
          chain_q      <= 1'b0;
          wdog_q       <= '0;
          orig_valid_q <= 1'b0;
          map_valid_q  <= 1'b0;
          eq_valid_q   <= 1'b0;
        end else begin
          wdog_q <= wdog_q + WD_ONE;
        end
      end
    end
  end

  assign bus.clr_start     = clr_start_q;
  assign bus.acc_start     = acc_start_q;
  assign bus.acc_src       = acc_src_q;
  assign bus.cdf_start     = cdf_start_q;
  assign bus.map_start     = map_start_q;
  assign bus.hist_switch   = hist_switch_q;
  assign bus.busy          = busy_q;
  assign bus.cmd_reject    = cmd_reject_q;
  assign bus.error         = error_q;
  assign bus.condition_led = {busy_q | error_q, eq_valid_q, map_valid_q, orig_valid_q};

endmodule
`default_nettype wire
